// File: rtl/ofdm_peak_gate_n.sv
// OFDM short-preamble peak gate.
// Buffers the joint sample stream in a delay RAM, finds the timing-metric peak
// after a threshold crossing, and emits a framed burst of delayed samples that
// starts a programmable distance before the peak. o_tuser carries the phase
// captured at the peak.
module ofdm_peak_gate_n #(
    parameter int unsigned WIDTH_D      = 16,
    parameter int unsigned WIDTH_PHASE  = 32,
    parameter int unsigned WIDTH_SAMPLE = 16,
    parameter int unsigned DELAY_LOG2   = 9,
    parameter int unsigned MAX_SEARCH   = 160,
    parameter int unsigned SR_THRESHOLD = 5,
    parameter int unsigned SR_DROP      = 6,
    parameter int unsigned SR_BURST_LEN = 7,
    parameter int unsigned SR_ALIGN     = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [WIDTH_D-1:0]        i_metric,
    input  logic [WIDTH_PHASE-1:0]    i_phase,
    input  logic [2*WIDTH_SAMPLE-1:0] i_sample,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [2*WIDTH_SAMPLE-1:0] o_tdata,
    output logic [WIDTH_PHASE-1:0]    o_tuser,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic [15:0]               trig_count,
    output logic [15:0]               abort_count
);

    localparam int unsigned DEPTH = 1 << DELAY_LOG2;
    localparam int unsigned D     = DEPTH - 1;
    localparam int unsigned SW    = $clog2(MAX_SEARCH + 1);
    localparam int unsigned CW    = ((DELAY_LOG2 > SW) ? DELAY_LOG2 : SW) + 2;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ALIGN, S_BURST} state_t;

    // Live settings registers
    logic [WIDTH_D-1:0]    thr_q;
    logic [3:0]            ds_q;
    logic [15:0]           blen_q;
    logic [DELAY_LOG2-1:0] ab_q;

    // Per-detection copies latched at the threshold crossing
    logic [3:0]            ds_l_q;
    logic [15:0]           blen_l_q;
    logic [DELAY_LOG2-1:0] ab_l_q;

    state_t                   state_q;
    logic [DELAY_LOG2-1:0]    wr_ptr_q;
    logic [DELAY_LOG2-1:0]    fill_q;
    logic [WIDTH_D-1:0]       max_q;
    logic [WIDTH_PHASE-1:0]   phase_q;
    logic [SW-1:0]            dist_q;     // beats since the current max
    logic [DELAY_LOG2-1:0]    wait_q;     // beats left before the first burst sample
    logic [15:0]              cnt_q;      // samples emitted in this burst
    logic                     o_tvalid_q;
    logic                     o_tlast_q;
    logic [WIDTH_PHASE-1:0]   o_tuser_q;
    logic [15:0]              trig_q;
    logic [15:0]              abort_q;

    logic [2*WIDTH_SAMPLE-1:0] ram_q [DEPTH];
    logic [2*WIDTH_SAMPLE-1:0] rd_data_q;
    logic [DELAY_LOG2-1:0]     rd_addr;

    logic                  beat;
    logic [CW-1:0]         dist_inc_d;
    logic [CW-1:0]         align_sum_d;
    logic [DELAY_LOG2-1:0] wait_init_d;
    logic [WIDTH_D-1:0]    drop_level_d;
    logic                  emit_d;
    logic                  last_d;
    logic                  unused_set_data;

    assign unused_set_data = ^set_data;
    assign i_tready        = ~o_tvalid_q | o_tready;
    assign beat            = i_tvalid & i_tready;
    // The slot after the write pointer holds the sample written D beats ago.
    assign rd_addr         = wr_ptr_q + 1'b1;

    assign o_tvalid    = o_tvalid_q;
    assign o_tlast     = o_tlast_q;
    assign o_tuser     = o_tuser_q;
    assign o_tdata     = o_tvalid_q ? rd_data_q : '0;
    assign trig_count  = trig_q;
    assign abort_count = abort_q;

    // Settings bus decode; new values only take effect at the next detection.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            thr_q  <= '0;
            ds_q   <= '0;
            blen_q <= '0;
            ab_q   <= '0;
        end else if (set_stb) begin
            case (set_addr)
                8'(SR_THRESHOLD): thr_q  <= set_data[WIDTH_D-1:0];
                8'(SR_DROP):      ds_q   <= set_data[3:0];
                8'(SR_BURST_LEN): blen_q <= set_data[15:0];
                8'(SR_ALIGN):     ab_q   <= set_data[DELAY_LOG2-1:0];
                default: ;
            endcase
        end
    end

    // Delay RAM: write the new sample, read the one from D beats earlier.
    always_ff @(posedge clk) begin
        if (beat) begin
            ram_q[wr_ptr_q] <= i_sample;
            rd_data_q       <= ram_q[rd_addr];
        end
    end

    // Search distance, alignment slack, drop level and burst emission decode.
    always_comb begin
        dist_inc_d   = CW'(dist_q) + CW'(1);
        align_sum_d  = CW'(ab_l_q) + dist_inc_d;
        wait_init_d  = DELAY_LOG2'(CW'(D) - align_sum_d - CW'(1));
        drop_level_d = max_q - (max_q >> ds_l_q);
        emit_d       = beat && ((state_q == S_BURST) ||
                                ((state_q == S_ALIGN) && (wait_q == '0)));
        last_d       = ((cnt_q + 16'd1) == blen_l_q);
    end

    // Detection FSM, write pointer, fill tracking, output register and counters.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            max_q      <= '0;
            phase_q    <= '0;
            dist_q     <= '0;
            wait_q     <= '0;
            cnt_q      <= '0;
            ds_l_q     <= '0;
            blen_l_q   <= '0;
            ab_l_q     <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            o_tuser_q  <= '0;
            trig_q     <= '0;
            abort_q    <= '0;
        end else begin
            if (beat) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != DELAY_LOG2'(D)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end

            if (emit_d) begin
                o_tvalid_q <= 1'b1;
                o_tlast_q  <= last_d;
                o_tuser_q  <= phase_q;
            end else if (o_tready) begin
                o_tvalid_q <= 1'b0;
                o_tlast_q  <= 1'b0;
            end

            if (beat) begin
                case (state_q)
                    S_IDLE: begin
                        if ((fill_q == DELAY_LOG2'(D)) && (i_metric > thr_q)) begin
                            state_q  <= S_SEARCH;
                            max_q    <= i_metric;
                            phase_q  <= i_phase;
                            dist_q   <= '0;
                            ds_l_q   <= ds_q;
                            blen_l_q <= (blen_q == 16'd0) ? 16'd1 : blen_q;
                            ab_l_q   <= ab_q;
                        end
                    end
                    S_SEARCH: begin
                        if (i_metric > max_q) begin
                            max_q   <= i_metric;
                            phase_q <= i_phase;
                            dist_q  <= '0;
                        end else if (i_metric < drop_level_d) begin
                            // Peak confirmed; abort if its aligned start already left the RAM.
                            if (align_sum_d >= CW'(D)) begin
                                if (abort_q != 16'hFFFF) abort_q <= abort_q + 16'd1;
                                state_q <= S_IDLE;
                            end else begin
                                wait_q  <= wait_init_d;
                                cnt_q   <= '0;
                                state_q <= S_ALIGN;
                            end
                        end else if (dist_inc_d >= CW'(MAX_SEARCH)) begin
                            if (abort_q != 16'hFFFF) abort_q <= abort_q + 16'd1;
                            state_q <= S_IDLE;
                        end else begin
                            dist_q <= SW'(dist_inc_d);
                        end
                    end
                    S_ALIGN: begin
                        if (wait_q == '0) begin
                            if (trig_q != 16'hFFFF) trig_q <= trig_q + 16'd1;
                            cnt_q   <= cnt_q + 16'd1;
                            state_q <= last_d ? S_IDLE : S_BURST;
                        end else begin
                            wait_q <= wait_q - 1'b1;
                        end
                    end
                    S_BURST: begin
                        cnt_q <= cnt_q + 16'd1;
                        if (last_d) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofdm_peak_gate_n.sv
// Bench for ofdm_peak_gate_n: directed metric profiles with random samples,
// phases and output backpressure, checked against an index-based model.
module tb_ofdm_peak_gate_n;

    localparam int D          = 511;
    localparam int MAX_SEARCH = 160;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [15:0] i_metric = '0;
    logic [31:0] i_phase = '0;
    logic [31:0] i_sample = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic [31:0] o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;
    logic [15:0] trig_count;
    logic [15:0] abort_count;

    ofdm_peak_gate_n dut (
        .clk(clk), .aresetn(aresetn),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_metric(i_metric), .i_phase(i_phase), .i_sample(i_sample),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .trig_count(trig_count), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] user;
        logic        last;
    } out_t;

    int checks = 0;
    int errors = 0;
    int scen   = 0;
    int s_thr, s_ds, s_blen, s_ab;

    logic [15:0] h_metric [$];
    logic [31:0] h_phase  [$];
    logic [31:0] h_sample [$];
    out_t        obs      [$];

    bit          have_pending = 0;
    bit          prev_stall   = 0;
    logic [31:0] prev_data, prev_user;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [15:0] metric_at(input int k);
        logic [15:0] noise;
        noise = 16'($urandom_range(0, 900));
        case (scen)
            1: begin
                if (k >= 600 && k <= 620) return 16'(1100 + (k - 600) * 145);
                if (k == 621) return 16'd3000;
            end
            3: if (k >= 520 && k <= 680) return 16'd2000;
            4: begin
                if (k == 530) return 16'd4000;
                if (k >= 531 && k <= 534) return 16'd3900;
                if (k == 535) return 16'd100;
            end
            5: begin
                if (k == 600)  return 16'd4000;
                if (k == 601)  return 16'd3000;
                if (k == 1098) return 16'd5000;
                if (k == 1103) return 16'd4000;
                if (k == 1104) return 16'd100;
            end
            6: if (k <= 515) return 16'd4000;
            default: ;
        endcase
        return noise;
    endfunction

    // One clock of stimulus and observation, all from the falling edge.
    task automatic step(input int ready_pct, input bit feeding);
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", 64'(o_tvalid), 64'd1);
            chk("stall_data", 64'(o_tdata), 64'(prev_data));
            chk("stall_user", 64'(o_tuser), 64'(prev_user));
            chk("stall_last", 64'(o_tlast), 64'(prev_last));
        end
        o_tready = ($urandom_range(0, 99) < ready_pct);
        if (feeding) begin
            if (!have_pending) begin
                i_metric = metric_at(h_metric.size());
                i_phase  = $urandom;
                i_sample = $urandom;
                have_pending = 1;
            end
            i_tvalid = 1'b1;
        end else begin
            i_tvalid = 1'b0;
        end
        #1;
        if (o_tvalid && o_tready)
            obs.push_back(out_t'{data: o_tdata, user: o_tuser, last: o_tlast});
        if (i_tvalid && i_tready) begin
            h_metric.push_back(i_metric);
            h_phase.push_back(i_phase);
            h_sample.push_back(i_sample);
            have_pending = 0;
        end
        prev_stall = o_tvalid && !o_tready;
        prev_data  = o_tdata;
        prev_user  = o_tuser;
        prev_last  = o_tlast;
    endtask

    task automatic feed(input int n, input int ready_pct, input bit drain);
        int budget;
        budget = n * 20 + 100;
        while (h_metric.size() < n && budget > 0) begin
            step(ready_pct, 1'b1);
            budget--;
        end
        chk("feed_done", 64'(h_metric.size()), 64'(n));
        if (drain) repeat (4) step(100, 1'b0);
    endtask

    task automatic write_set(input int addr, input int data);
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = 32'(data);
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic set_all(input int thr, input int ds, input int blen, input int ab);
        write_set(5, thr);
        write_set(6, ds);
        write_set(7, blen);
        write_set(8, ab);
        s_thr = thr; s_ds = ds; s_blen = blen; s_ab = ab;
    endtask

    task automatic clear_hist();
        h_metric.delete(); h_phase.delete(); h_sample.delete(); obs.delete();
        have_pending = 0;
        prev_stall   = 0;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        set_stb  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        #12;
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_tdata", 64'(o_tdata), 64'd0);
        chk("rst_tuser", 64'(o_tuser), 64'd0);
        chk("rst_trig", 64'(trig_count), 64'd0);
        chk("rst_abort", 64'(abort_count), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        clear_hist();
    endtask

    // Replays the recorded beats with absolute indices and compares the result.
    task automatic check_model(input string tag);
        out_t exp_q [$];
        int st, p, mx, tgt, cnt, trig, abrt, blen, m;
        logic [31:0] ph;
        st = 0; p = 0; mx = 0; tgt = 0; cnt = 0; trig = 0; abrt = 0; ph = '0;
        blen = (s_blen == 0) ? 1 : s_blen;
        for (int k = 0; k < h_metric.size(); k++) begin
            m = int'(h_metric[k]);
            case (st)
                0: if (k >= D && m > s_thr) begin
                    st = 1; p = k; mx = m; ph = h_phase[k];
                end
                1: begin
                    if (m > mx) begin
                        mx = m; p = k; ph = h_phase[k];
                    end else if (m < mx - (mx >> s_ds)) begin
                        if (s_ab + (k - p) >= D) begin
                            abrt++; st = 0;
                        end else begin
                            tgt = p - s_ab; cnt = 0; st = 2;
                        end
                    end else if (k - p >= MAX_SEARCH) begin
                        abrt++; st = 0;
                    end
                end
                default: begin
                    if (st == 3 || k - D == tgt) begin
                        if (st == 2) trig++;
                        cnt++;
                        exp_q.push_back(out_t'{data: h_sample[k - D], user: ph, last: (cnt == blen)});
                        st = (cnt == blen) ? 0 : 3;
                    end
                end
            endcase
        end
        chk({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk({tag, "_data"}, 64'(obs[i].data), 64'(exp_q[i].data));
            chk({tag, "_user"}, 64'(obs[i].user), 64'(exp_q[i].user));
            chk({tag, "_last"}, 64'(obs[i].last), 64'(exp_q[i].last));
        end
        chk({tag, "_trig"}, 64'(trig_count), 64'(trig));
        chk({tag, "_abort"}, 64'(abort_count), 64'(abrt));
        $display("%s: %0d beats, %0d outputs, trig=%0d abort=%0d", tag, h_metric.size(), obs.size(), trig_count, abort_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Peak burst, free-running output
        do_reset();
        set_all(1000, 3, 64, 16);
        scen = 1;
        feed(1200, 100, 1'b1);
        check_model("peak");

        // Same stream under random backpressure
        do_reset();
        set_all(1000, 3, 64, 16);
        scen = 1;
        feed(1200, 50, 1'b1);
        check_model("stall");

        // Plateau without a drop: search timeout
        do_reset();
        set_all(1000, 3, 64, 16);
        scen = 3;
        feed(900, 100, 1'b1);
        check_model("timeout");

        // Alignment reaching further back than the RAM holds
        do_reset();
        set_all(1000, 3, 64, D - 2);
        scen = 4;
        feed(800, 100, 1'b1);
        check_model("align_abort");

        // Crossing inside a burst ignored, crossing right after tlast detected
        do_reset();
        set_all(1000, 3, 8, 16);
        scen = 5;
        feed(1700, 70, 1'b1);
        check_model("retrigger");

        // Reset in the middle of a burst
        do_reset();
        set_all(1000, 3, 64, 16);
        scen = 1;
        feed(1130, 100, 1'b0);
        @(negedge clk);
        o_tready = 1'b0;
        i_tvalid = 1'b0;
        #1;
        chk("midburst_valid", 64'(o_tvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_tvalid), 64'd0);
        chk("midrst_last", 64'(o_tlast), 64'd0);
        chk("midrst_trig", 64'(trig_count), 64'd0);
        #13;
        aresetn = 1'b1;
        clear_hist();
        set_all(1000, 3, 64, 16);
        scen = 6;
        feed(1100, 70, 1'b1);
        check_model("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
